cam_bram_mm: RTL and testbench

//  Parametrised BRAM CAM: sliced one-hot match RAMs plus a shadow RAM of entry contents.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_slice_ram.sv | 29 ++
 rtl/priority_encoder.sv | 20 ++
 rtl/cam_bram_mm.sv | 241 ++++++++++++++++++++++++
 tb/tb_cam_bram_mm.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the BRAM CAM: FSM state encodings and slice geometry helpers.
package cam_pkg;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_DEL_RD = 3'd2;
    localparam logic [2:0] ST_DEL_WR = 3'd3;
    localparam logic [2:0] ST_OVR_RD = 3'd4;
    localparam logic [2:0] ST_OVR_WR = 3'd5;
    localparam logic [2:0] ST_WR_RD  = 3'd6;
    localparam logic [2:0] ST_WR_WR  = 3'd7;

    function automatic int slice_count(input int data_width, input int slice_width);
        return (data_width + slice_width - 1) / slice_width;
    endfunction

    function automatic int padded_width(input int data_width, input int slice_width);
        return slice_count(data_width, slice_width) * slice_width;
    endfunction

endpackage

// File: rtl/cam_slice_ram.sv
// One CAM slice: a dual-port RAM holding a one-hot entry vector per slice key value.
// Port A is the compare read, port B is the read-modify-write port used by the FSM.
module cam_slice_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_we,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Compare port: registered read, returns pre-write contents on a same-cycle write
    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
    end

    // Maintenance port: read-first so the FSM can modify the word it read last cycle
    always_ff @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_wdata;
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports the lowest set request bit.
module priority_encoder #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 5
) (
    input  logic [WIDTH-1:0]     req,
    output logic                 any,
    output logic [OUT_WIDTH-1:0] index
);

    // Scan from the top down so the lowest set bit is the last one to write index
    always_comb begin
        any   = |req;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) index = OUT_WIDTH'(i);
        end
    end

endmodule

// File: rtl/cam_bram_mm.sv
// BRAM CAM key-match engine: sliced one-hot match RAMs, shadow key RAM, per-entry valid bits,
// handshaked write/delete/flush FSM and a fixed two-cycle compare pipeline.
// Optional macro CAM_BRAM_MM_MATCH_COUNT_EN adds the match_count popcount output.
module cam_bram_mm
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_WIDTH-1:0]    write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_delete,
    input  logic                     write_valid,
    output logic                     write_ready,
    output logic                     write_done,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    compare_data,
    input  logic                     compare_valid,
    output logic                     match_valid,
    output logic                     match,
    output logic [ADDR_WIDTH-1:0]    match_addr,
    output logic [2**ADDR_WIDTH-1:0] match_many
`ifdef CAM_BRAM_MM_MATCH_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]      match_count
`endif
);

    localparam int RAM_DEPTH   = 2**ADDR_WIDTH;
    localparam int SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH);
    localparam int PAD_WIDTH   = padded_width(DATA_WIDTH, SLICE_WIDTH);
    localparam logic [SLICE_WIDTH-1:0] INIT_LAST = '1;

    logic [2:0]             state;
    logic [SLICE_WIDTH-1:0] init_cnt;
    logic [RAM_DEPTH-1:0]   entry_valid;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [DATA_WIDTH-1:0]  cmd_data;
    logic [DATA_WIDTH-1:0]  shadow_q;
    logic [DATA_WIDTH-1:0]  shadow_mem [RAM_DEPTH];
    logic                   accept;
    logic [RAM_DEPTH-1:0]   entry_bit;
    logic [PAD_WIDTH-1:0]   cmp_pad;
    logic [PAD_WIDTH-1:0]   old_pad;
    logic [PAD_WIDTH-1:0]   new_pad;
    logic [RAM_DEPTH-1:0]   a_rdata [SLICE_COUNT];
    logic [RAM_DEPTH-1:0]   b_rdata [SLICE_COUNT];
    logic [RAM_DEPTH-1:0]   b_wdata [SLICE_COUNT];
    logic [SLICE_WIDTH-1:0] b_addr  [SLICE_COUNT];
    logic                   b_we;
    logic                   c1_valid;
    logic [RAM_DEPTH-1:0]   c1_entry_valid;
    logic [RAM_DEPTH-1:0]   hit_vec;
    logic                   hit_any;
    logic [ADDR_WIDTH-1:0]  hit_addr;

    assign write_ready = (state == ST_IDLE);
    assign accept      = write_ready && write_valid && !flush;
    assign entry_bit   = RAM_DEPTH'(1) << cmd_addr;

    // Zero-extension forces the pad bits of the last slice to 0 in every slice address
    assign cmp_pad = PAD_WIDTH'(compare_data);
    assign old_pad = PAD_WIDTH'(shadow_q);
    assign new_pad = PAD_WIDTH'(cmd_data);

    for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
        cam_slice_ram #(
            .ADDR_WIDTH (SLICE_WIDTH),
            .DATA_WIDTH (RAM_DEPTH)
        ) u_ram (
            .clk     (clk),
            .a_addr  (cmp_pad[s*SLICE_WIDTH +: SLICE_WIDTH]),
            .a_rdata (a_rdata[s]),
            .b_addr  (b_addr[s]),
            .b_we    (b_we),
            .b_wdata (b_wdata[s]),
            .b_rdata (b_rdata[s])
        );
    end

    // Port-B steering: sweep-clear in INIT, old key for delete/overwrite, new key for writes
    always_comb begin
        b_we = 1'b0;
        for (int s = 0; s < SLICE_COUNT; s++) begin
            b_addr[s]  = new_pad[s*SLICE_WIDTH +: SLICE_WIDTH];
            b_wdata[s] = b_rdata[s] | entry_bit;
        end
        case (state)
            ST_INIT: begin
                b_we = 1'b1;
                for (int s = 0; s < SLICE_COUNT; s++) begin
                    b_addr[s]  = init_cnt;
                    b_wdata[s] = '0;
                end
            end
            ST_DEL_RD, ST_OVR_RD: begin
                for (int s = 0; s < SLICE_COUNT; s++) begin
                    b_addr[s] = old_pad[s*SLICE_WIDTH +: SLICE_WIDTH];
                end
            end
            ST_DEL_WR, ST_OVR_WR: begin
                b_we = 1'b1;
                for (int s = 0; s < SLICE_COUNT; s++) begin
                    b_addr[s]  = old_pad[s*SLICE_WIDTH +: SLICE_WIDTH];
                    b_wdata[s] = b_rdata[s] & ~entry_bit;
                end
            end
            ST_WR_WR: b_we = 1'b1;
            default: ;
        endcase
    end

    // Command FSM: init sweep, accept/flush in IDLE, erase-then-write sequencing, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            init_cnt    <= INIT_LAST;
            entry_valid <= '0;
            write_done  <= 1'b0;
            cmd_addr    <= '0;
            cmd_data    <= '0;
        end else begin
            write_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt - 1'b1;
                    if (init_cnt == '0) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (flush) begin
                        state       <= ST_INIT;
                        init_cnt    <= INIT_LAST;
                        entry_valid <= '0;
                    end else if (write_valid) begin
                        cmd_addr <= write_addr;
                        cmd_data <= write_data;
                        if (write_delete)                 state <= ST_DEL_RD;
                        else if (entry_valid[write_addr]) state <= ST_OVR_RD;
                        else                              state <= ST_WR_RD;
                    end
                end
                ST_DEL_RD: begin
                    if (entry_valid[cmd_addr]) begin
                        state <= ST_DEL_WR;
                    end else begin
                        state      <= ST_IDLE;
                        write_done <= 1'b1;
                    end
                end
                ST_DEL_WR: begin
                    entry_valid[cmd_addr] <= 1'b0;
                    state                 <= ST_IDLE;
                    write_done            <= 1'b1;
                end
                ST_OVR_RD: state <= ST_OVR_WR;
                ST_OVR_WR: state <= ST_WR_RD;
                ST_WR_RD:  state <= ST_WR_WR;
                ST_WR_WR: begin
                    entry_valid[cmd_addr] <= 1'b1;
                    state                 <= ST_IDLE;
                    write_done            <= 1'b1;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Shadow key RAM: old key fetched on accept so delete/overwrite know which bits to clear
    always_ff @(posedge clk) begin
        if (state == ST_WR_WR) shadow_mem[cmd_addr] <= cmd_data;
        if (accept) shadow_q <= shadow_mem[write_addr];
    end

    // Compare stage C0: valid bits snapshot alongside the slice RAM read for a consistent view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_valid       <= 1'b0;
            c1_entry_valid <= '0;
        end else begin
            c1_valid       <= compare_valid;
            c1_entry_valid <= entry_valid;
        end
    end

    // An entry matches only when every slice RAM has its bit set and the entry is valid
    always_comb begin
        hit_vec = c1_entry_valid;
        for (int s = 0; s < SLICE_COUNT; s++) begin
            hit_vec = hit_vec & a_rdata[s];
        end
    end

    priority_encoder #(
        .WIDTH     (RAM_DEPTH),
        .OUT_WIDTH (ADDR_WIDTH)
    ) u_prio (
        .req   (hit_vec),
        .any   (hit_any),
        .index (hit_addr)
    );

`ifdef CAM_BRAM_MM_MATCH_COUNT_EN
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    logic [ADDR_WIDTH:0] hit_count;

    // Number of matching entries, registered together with the other results
    always_comb begin
        hit_count = '0;
        for (int e = 0; e < RAM_DEPTH; e++) begin
            hit_count = hit_count + CNT_WIDTH'(hit_vec[e]);
        end
    end
`endif

    // Compare stage C1: result registers update only for a valid request, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_valid <= 1'b0;
            match       <= 1'b0;
            match_addr  <= '0;
            match_many  <= '0;
`ifdef CAM_BRAM_MM_MATCH_COUNT_EN
            match_count <= '0;
`endif
        end else begin
            match_valid <= c1_valid;
            if (c1_valid) begin
                match      <= hit_any;
                match_addr <= hit_addr;
                match_many <= hit_vec;
`ifdef CAM_BRAM_MM_MATCH_COUNT_EN
                match_count <= hit_count;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cam_bram_mm.sv
// Self-checking bench for cam_bram_mm (16-bit keys, 8 entries, 4-bit slices).
// Compare expectations come from a small key/valid model and flow through a scoreboard queue.
module tb_cam_bram_mm;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int SW    = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     write_addr = '0;
    logic [DW-1:0]     write_data = '0;
    logic              write_delete = 1'b0;
    logic              write_valid = 1'b0;
    logic              write_ready;
    logic              write_done;
    logic              flush = 1'b0;
    logic [DW-1:0]     compare_data = '0;
    logic              compare_valid = 1'b0;
    logic              match_valid;
    logic              match;
    logic [AW-1:0]     match_addr;
    logic [DEPTH-1:0]  match_many;
`ifdef CAM_BRAM_MM_MATCH_COUNT_EN
    logic [AW:0]       match_count;
`endif

    always #5 clk = ~clk;

    cam_bram_mm #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SLICE_WIDTH (SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_delete  (write_delete),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .write_done    (write_done),
        .flush         (flush),
        .compare_data  (compare_data),
        .compare_valid (compare_valid),
        .match_valid   (match_valid),
        .match         (match),
        .match_addr    (match_addr),
        .match_many    (match_many)
`ifdef CAM_BRAM_MM_MATCH_COUNT_EN
        ,
        .match_count   (match_count)
`endif
    );

    typedef struct packed {
        logic             hit;
        logic [AW-1:0]    addr;
        logic [DEPTH-1:0] many;
    } result_t;

    result_t          exp_q[$];
    logic [DW-1:0]    model_key [DEPTH];
    logic [DEPTH-1:0] model_valid = '0;

    logic             pend = 1'b0;
    logic             pend_del = 1'b0;
    logic [AW-1:0]    pend_addr = '0;
    logic [DW-1:0]    pend_data = '0;
    int               pend_cnt = 0;
    int               pend_exp = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic result_t expect_for(input logic [DW-1:0] key);
        result_t r;
        r.hit  = 1'b0;
        r.addr = '0;
        r.many = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (model_valid[e] && model_key[e] == key) begin
                r.many[e] = 1'b1;
                r.hit     = 1'b1;
                r.addr    = AW'(e);
            end
        end
        return r;
    endfunction

    // Advance to the next falling edge, idle the command inputs and track write completion
    task automatic next_cycle();
        @(negedge clk);
        compare_valid = 1'b0;
        write_valid   = 1'b0;
        flush         = 1'b0;
        write_addr    = AW'($urandom);
        write_data    = DW'($urandom);
        write_delete  = 1'($urandom_range(0, 1));
        if (pend) begin
            if (write_done === 1'b1) begin
                checkOutput("done_latency", pend_cnt, pend_exp);
                if (pend_del) begin
                    model_valid[pend_addr] = 1'b0;
                end else begin
                    model_key[pend_addr]   = pend_data;
                    model_valid[pend_addr] = 1'b1;
                end
                pend = 1'b0;
            end else begin
                pend_cnt++;
                if (pend_cnt > 12) begin
                    checkOutput("done_timeout", pend_cnt, pend_exp);
                    pend = 1'b0;
                end
            end
        end else if (rst_n === 1'b1) begin
            checkOutput("no_stray_done", write_done, 0);
        end
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic del);
        checkOutput("ready_before_accept", write_ready, 1);
        write_addr   = a;
        write_data   = d;
        write_delete = del;
        write_valid  = 1'b1;
        pend         = 1'b1;
        pend_del     = del;
        pend_addr    = a;
        pend_data    = d;
        pend_cnt     = 0;
        pend_exp     = del ? (model_valid[a] ? 2 : 1) : (model_valid[a] ? 4 : 2);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && pend; i++) next_cycle();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic del);
        next_cycle();
        issue_write(a, d, del);
        next_cycle();
        checkOutput("ready_drop", write_ready, 0);
        wait_done();
    endtask

    task automatic applyStimulus(input logic [DW-1:0] key);
        compare_data  = key;
        compare_valid = 1'b1;
        exp_q.push_back(expect_for(key));
    endtask

    task automatic compare_one(input logic [DW-1:0] key);
        next_cycle();
        applyStimulus(key);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) next_cycle();
        checkOutput("drain", exp_q.size(), 0);
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (write_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            next_cycle();
        end
        checkOutput(tag, cnt, 1 << SW);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_ready"}, write_ready, 0);
        checkOutput({tag, "_done"}, write_done, 0);
        checkOutput({tag, "_match_valid"}, match_valid, 0);
        checkOutput({tag, "_match"}, match, 0);
        checkOutput({tag, "_match_addr"}, match_addr, 0);
        checkOutput({tag, "_match_many"}, match_many, 0);
    endtask

    // Scoreboard consumer: every valid result must line up with the oldest outstanding compare
    always @(negedge clk) begin
        result_t e;
        if (rst_n === 1'b1 && match_valid === 1'b1) begin
            checkOutput("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("match", match, e.hit);
                checkOutput("match_many", match_many, e.many);
                if (e.hit) checkOutput("match_addr", match_addr, e.addr);
`ifdef CAM_BRAM_MM_MATCH_COUNT_EN
                checkOutput("match_count", match_count, $countones(e.many));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state and init sweep length
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_init("reset_init_cycles");
        compare_one(16'h0000);
        drain();

        // Write to an empty entry, then find it
        do_write(3'd3, 16'hBEEF, 1'b0);
        compare_one(16'hBEEF);
        drain();

        // Overwrite erases the old key
        do_write(3'd3, 16'h1234, 1'b0);
        compare_one(16'hBEEF);
        compare_one(16'h1234);
        drain();

        // Same key twice, then deletes (one of an empty entry)
        do_write(3'd5, 16'hAAAA, 1'b0);
        do_write(3'd2, 16'hAAAA, 1'b0);
        compare_one(16'hAAAA);
        drain();
        do_write(3'd2, 16'h0000, 1'b1);
        compare_one(16'hAAAA);
        drain();
        do_write(3'd6, 16'h0000, 1'b1);
        compare_one(16'hAAAA);
        drain();

        // Flush with three entries, raised together with a write it must override
        do_write(3'd0, 16'h0F0F, 1'b0);
        compare_one(16'h0F0F);
        drain();
        next_cycle();
        checkOutput("ready_before_flush", write_ready, 1);
        flush        = 1'b1;
        write_valid  = 1'b1;
        write_addr   = 3'd7;
        write_data   = 16'h7777;
        write_delete = 1'b0;
        model_valid  = '0;
        next_cycle();
        wait_init("flush_init_cycles");
        compare_one(16'h1234);
        compare_one(16'hAAAA);
        compare_one(16'h0F0F);
        compare_one(16'h7777);
        drain();

        // Back-to-back compares across a write, including the commit edge
        next_cycle();
        issue_write(3'd1, 16'h5555, 1'b0);
        applyStimulus(16'h5555);
        for (int i = 1; i < 8; i++) begin
            next_cycle();
            if (i < 6) applyStimulus(16'h5555);
            if (i >= 2) checkOutput("b2b_match_valid", match_valid, 1);
        end
        wait_done();
        drain();

        // Reset in the middle of an overwrite abandons it
        next_cycle();
        issue_write(3'd1, 16'h6666, 1'b0);
        next_cycle();
        next_cycle();
        pend  = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) next_cycle();
        rst_n = 1'b1;
        model_valid = '0;
        exp_q.delete();
        wait_init("mid_reset_init_cycles");
        compare_one(16'h5555);
        compare_one(16'h6666);
        drain();
        repeat (3) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
